// File: rtl/move_link_rx.sv
// Receive end of the board-to-board move link: synchronises and filters the
// opponent's strobe, validates the move code and emits one-cycle move pulses.
module move_link_rx #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic receive,
    input  logic left_data,
    input  logic right_data,
    input  logic remote_turn,
    input  logic err_clear,
    output logic left_pulse,
    output logic right_pulse,
    output logic put_pulse,
    output logic busy,
    output logic code_err,
    output logic turn_err,
    output logic stuck_err
);

    typedef enum logic [2:0] {IDLE, ARMING, DECODE, HOLD, RELEASE} state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [2:0]       sync_m, sync_s;
    logic             rx_s;
    logic [1:0]       code_s;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       pulse_n;
    logic             set_code, set_turn, set_stuck;

    // Bit order {right, left, strobe}; each wire gets its own 2-flop synchroniser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_m <= '0;
            sync_s <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            sync_m <= {right_data, left_data, receive};
            sync_s <= sync_m;
        end
    end

    assign rx_s   = sync_s[0];
    assign code_s = sync_s[2:1];

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_n   = state;
        cnt_n     = cnt;
        pulse_n   = '0;
        set_code  = 1'b0;
        set_turn  = 1'b0;
        set_stuck = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_s) begin
                    state_n = ARMING;
                    cnt_n   = CNT_ONE;
                end
            end
            ARMING: begin
                if (!rx_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_n = DECODE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            DECODE: begin
                state_n = HOLD;
                cnt_n   = '0;
                if (!remote_turn)
                    set_turn = 1'b1;
                else if (code_s == 2'b00)
                    set_code = 1'b1;
                else
                    pulse_n = {code_s == 2'b11, code_s == 2'b10, code_s == 2'b01};
            end
            HOLD: begin
                if (!rx_s) begin
                    state_n = RELEASE;
                    cnt_n   = CNT_ONE;
                end else if (cnt >= TIMEOUT_CNT) begin
                    set_stuck = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            RELEASE: begin
                // A short high glitch while releasing means the strobe is still on.
                if (rx_s) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            left_pulse  <= 1'b0;
            right_pulse <= 1'b0;
            put_pulse   <= 1'b0;
            code_err    <= 1'b0;
            turn_err    <= 1'b0;
            stuck_err   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            left_pulse  <= pulse_n[0];
            right_pulse <= pulse_n[1];
            put_pulse   <= pulse_n[2];
            // Set has priority over a simultaneous clear.
            code_err    <= set_code  | (code_err  & ~err_clear);
            turn_err    <= set_turn  | (turn_err  & ~err_clear);
            stuck_err   <= set_stuck | (stuck_err & ~err_clear);
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_move_link_rx.sv
// Randomised bench for move_link_rx: strobe segments are applied and the
// expected pulses/errors are scheduled per cycle from the link's timing rules.
module tb_move_link_rx;

    localparam int S = 4;
    localparam int T = 50;

    localparam int EV_LEFT  = 0;
    localparam int EV_RIGHT = 1;
    localparam int EV_PUT   = 2;
    localparam int EV_TURN  = 3;
    localparam int EV_CODE  = 4;
    localparam int EV_STUCK = 5;
    localparam int EV_CLEAR = 6;

    logic clk = 1'b0;
    logic rst, receive, left_data, right_data, remote_turn, err_clear;
    logic left_pulse, right_pulse, put_pulse, busy, code_err, turn_err, stuck_err;

    move_link_rx #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .receive(receive), .left_data(left_data),
        .right_data(right_data), .remote_turn(remote_turn), .err_clear(err_clear),
        .left_pulse(left_pulse), .right_pulse(right_pulse), .put_pulse(put_pulse),
        .busy(busy), .code_err(code_err), .turn_err(turn_err), .stuck_err(stuck_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: expected events keyed by the cycle in which they become visible.
    logic [6:0] ev [int];
    bit e_code, e_turn, e_stuck;
    bit chk_en   = 1'b0;
    bit accepted = 1'b0;

    task automatic add_ev(input int c, input int b);
        logic [6:0] v;
        v = ev.exists(c) ? ev[c] : 7'd0;
        v[b] = 1'b1;
        ev[c] = v;
    endtask

    // Strobe rising at drive cycle k: 2 sync + S filter + 1 register -> visible at k+S+3.
    task automatic expect_decode(input int k, input logic [1:0] code, input bit turn);
        if (!turn)
            add_ev(k + S + 3, EV_TURN);
        else if (code == 2'b00)
            add_ev(k + S + 3, EV_CODE);
        else
            add_ev(k + S + 3, int'(code) - 1);
    endtask

    always @(negedge clk) begin
        logic [6:0] e;
        if (chk_en) begin
            e = ev.exists(cyc) ? ev[cyc] : 7'd0;
            if (rst) begin
                e = '0;
                e_code = 0; e_turn = 0; e_stuck = 0;
            end else begin
                if (e[EV_CLEAR]) begin
                    e_code = 0; e_turn = 0; e_stuck = 0;
                end
                if (e[EV_CODE])  e_code  = 1;
                if (e[EV_TURN])  e_turn  = 1;
                if (e[EV_STUCK]) e_stuck = 1;
            end
            check("left_pulse",  left_pulse,  e[EV_LEFT]);
            check("right_pulse", right_pulse, e[EV_RIGHT]);
            check("put_pulse",   put_pulse,   e[EV_PUT]);
            check("code_err",    code_err,    e_code);
            check("turn_err",    turn_err,    e_turn);
            check("stuck_err",   stuck_err,   e_stuck);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raw strobe high for h cycles; code/turn held until well after decode, then changed.
    task automatic drive_high(input int h, input logic [1:0] code, input bit turn);
        int  k;
        bit  fresh;
        logic [1:0] nc;
        step();
        receive = 1'b1;
        {right_data, left_data} = code;
        remote_turn = turn;
        k = cyc;
        fresh = !accepted;
        if (fresh && h >= S) begin
            accepted = 1'b1;
            expect_decode(k, code, turn);
            if (h >= S + T + 2)
                add_ev(k + S + 4 + T, EV_STUCK);
        end
        for (int i = 1; i < h; i++) begin
            step();
            if (fresh && h >= S + 2 && i == S + 1)
                check("busy_strobe", busy, 1);
            if (i == S + 6) begin
                nc = 2'($urandom_range(0, 3));
                {right_data, left_data} = nc;
                remote_turn = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic drive_low(input int l, input bit do_clear);
        step();
        receive = 1'b0;
        if (accepted && l >= S)
            accepted = 1'b0;
        for (int i = 1; i < l; i++) begin
            step();
            if (do_clear && !accepted && l >= 8 && i == 5) begin
                err_clear = 1'b1;
                add_ev(cyc + 1, EV_CLEAR);
            end
            if (i == 6)
                err_clear = 1'b0;
        end
        if (!accepted && l >= S + 3)
            check("busy_idle", busy, 0);
    endtask

    initial begin
        int r, h;
        logic [1:0] code;
        bit turn;

        rst = 1'b1; receive = 0; left_data = 0; right_data = 0;
        remote_turn = 0; err_clear = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_left",  left_pulse,  0);
        check("rst_right", right_pulse, 0);
        check("rst_put",   put_pulse,   0);
        check("rst_busy",  busy,        0);
        check("rst_code",  code_err,    0);
        check("rst_turn",  turn_err,    0);
        check("rst_stuck", stuck_err,   0);
        step();
        rst = 1'b0;
        chk_en = 1'b1;

        // Directed scenarios.
        drive_high(20, 2'b01, 1); drive_low(10, 0);           // basic left
        drive_high(20, 2'b11, 1); drive_low(10, 0);           // put, code changes mid-strobe
        drive_high(3, 2'b01, 1);  drive_low(8, 0);            // glitch
        drive_high(10, 2'b10, 0); drive_low(8, 0);            // out of turn
        drive_high(10, 2'b00, 1); drive_low(10, 1);           // illegal code, then clear
        drive_high(100, 2'b01, 1); drive_low(10, 0);          // stuck strobe
        drive_high(10, 2'b01, 1); drive_low(S, 0);            // back-to-back, S low cycles
        drive_high(10, 2'b10, 1); drive_low(2, 0);            // 2-cycle low: same strobe
        drive_high(8, 2'b11, 1);  drive_low(10, 1);

        // Randomised strobes.
        for (int n = 0; n < 150; n++) begin
            r    = $urandom_range(0, 9);
            code = 2'($urandom_range(0, 3));
            turn = ($urandom_range(0, 3) != 0);
            if (r == 0) begin
                drive_high($urandom_range(1, S - 1), code, turn);
            end else begin
                h = (r == 1) ? $urandom_range(S + T + 5, S + T + 20) : $urandom_range(S + 2, 25);
                drive_high(h, code, turn);
                if ($urandom_range(0, 9) < 3) begin
                    drive_low($urandom_range(1, S - 1), 0);
                    drive_high($urandom_range(1, 10), code, turn);
                end
            end
            drive_low($urandom_range(S, 14), 1'($urandom_range(0, 1)));
        end

        // Reset while in HOLD, then a strobe still high after release.
        step();
        receive = 1'b1; {right_data, left_data} = 2'b01; remote_turn = 1'b1;
        expect_decode(cyc, 2'b01, 1);
        repeat (S + 6) step();
        ev.delete();
        rst = 1'b1;
        #1;
        check("hold_rst_left",  left_pulse, 0);
        check("hold_rst_busy",  busy,       0);
        check("hold_rst_stuck", stuck_err,  0);
        step();
        step();
        rst = 1'b0;
        {right_data, left_data} = 2'b10;
        expect_decode(cyc, 2'b10, 1);
        accepted = 1'b1;
        repeat (S + 8) step();
        drive_low(12, 0);

        repeat (5) step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
